// File: rtl/idex_fwd_stage.sv
// Decode->execute pipeline register with EX/MEM destination history, forwarding-control
// generation for both operands and load-use stall/bubble insertion.
module idex_fwd_stage #(
  parameter int unsigned CTRL_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_in,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [2:0]        id_rsA,
  input  logic              id_useA,
  input  logic [2:0]        id_rsB,
  input  logic              id_useB,
  input  logic              id_stuSel,
  input  logic              id_regWrite,
  input  logic [2:0]        id_wrReg,
  input  logic [1:0]        id_wbSel,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [15:0]       id_inA,
  input  logic [15:0]       id_inB,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [15:0]       ex_inA,
  output logic [15:0]       ex_inB,
  output logic [1:0]        ex_wbSel,
  output logic [4:0]        fwCntrlA,
  output logic [4:0]        fwCntrlB,
  output logic              stall_out
);

  localparam int unsigned REG_W  = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned WB_W   = 2;
  localparam int unsigned FW_W   = 5;
  localparam logic [WB_W-1:0] WB_MEM = WB_W'(1);

  typedef struct packed {
    logic             v;
    logic             reg_write;
    logic [REG_W-1:0] wr_reg;
    logic [WB_W-1:0]  wb_sel;
  } slot_t;

  slot_t             ex_slot, mem_slot;
  slot_t             ex_slot_nx, mem_slot_nx;
  logic              ex_valid_nx;
  logic [CTRL_W-1:0] ex_ctrl_nx;
  logic [DATA_W-1:0] ex_inA_nx, ex_inB_nx;
  logic [WB_W-1:0]   ex_wbSel_nx;
  logic [FW_W-1:0]   fwCntrlA_nx, fwCntrlB_nx;

  logic              x_a_c, x_b_c, m_a_c, m_b_c;
  logic              load_use_c;
  logic [FW_W-1:0]   fw_a_c, fw_b_c;

  // Destination matches against the in-flight EX and MEM producers
  always_comb begin
    x_a_c = ex_slot.v  & ex_slot.reg_write  & (ex_slot.wr_reg  == id_rsA);
    x_b_c = ex_slot.v  & ex_slot.reg_write  & (ex_slot.wr_reg  == id_rsB);
    m_a_c = mem_slot.v & mem_slot.reg_write & (mem_slot.wr_reg == id_rsA);
    m_b_c = mem_slot.v & mem_slot.reg_write & (mem_slot.wr_reg == id_rsB);
  end

  // Forwarding words; the younger EX producer wins over MEM
  always_comb begin
    fw_a_c = '0;
    fw_b_c = '0;
    if (id_useA & x_a_c)      fw_a_c[3:0] = {1'b1, 1'b0, ex_slot.wb_sel};
    else if (id_useA & m_a_c) fw_a_c[3:0] = {1'b1, 1'b1, mem_slot.wb_sel};
    if (id_useB & x_b_c)      fw_b_c[3:0] = {1'b1, 1'b0, ex_slot.wb_sel};
    else if (id_useB & m_b_c) fw_b_c[3:0] = {1'b1, 1'b1, mem_slot.wb_sel};
    fw_b_c[4] = id_stuSel;
  end

  // A load in EX cannot feed ID yet; a redirect makes the consumer irrelevant
  always_comb begin
    load_use_c = id_valid & ~flush
               & ((id_useA & x_a_c) | (id_useB & x_b_c))
               & (ex_slot.wb_sel == WB_MEM);
  end

  assign stall_out = load_use_c;

  // Next-state: hold on freeze, otherwise shift history and load ID or a bubble
  always_comb begin
    ex_slot_nx  = ex_slot;
    mem_slot_nx = mem_slot;
    ex_valid_nx = ex_valid;
    ex_ctrl_nx  = ex_ctrl;
    ex_inA_nx   = ex_inA;
    ex_inB_nx   = ex_inB;
    ex_wbSel_nx = ex_wbSel;
    fwCntrlA_nx = fwCntrlA;
    fwCntrlB_nx = fwCntrlB;
    if (!stall_in) begin
      mem_slot_nx = ex_slot;
      ex_slot_nx  = '0;
      ex_valid_nx = 1'b0;
      ex_ctrl_nx  = '0;
      ex_inA_nx   = '0;
      ex_inB_nx   = '0;
      ex_wbSel_nx = '0;
      fwCntrlA_nx = '0;
      fwCntrlB_nx = '0;
      if (!flush && !load_use_c && id_valid) begin
        ex_slot_nx.v         = 1'b1;
        ex_slot_nx.reg_write = id_regWrite;
        ex_slot_nx.wr_reg    = id_wrReg;
        ex_slot_nx.wb_sel    = id_wbSel;
        ex_valid_nx          = 1'b1;
        ex_ctrl_nx           = id_ctrl;
        ex_inA_nx            = id_inA;
        ex_inB_nx            = id_inB;
        ex_wbSel_nx          = id_wbSel;
        fwCntrlA_nx          = fw_a_c;
        fwCntrlB_nx          = fw_b_c;
      end
    end
  end

  // Stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_inA   <= '0;
      ex_inB   <= '0;
      ex_wbSel <= '0;
      fwCntrlA <= '0;
      fwCntrlB <= '0;
    end else begin
      ex_slot  <= ex_slot_nx;
      mem_slot <= mem_slot_nx;
      ex_valid <= ex_valid_nx;
      ex_ctrl  <= ex_ctrl_nx;
      ex_inA   <= ex_inA_nx;
      ex_inB   <= ex_inB_nx;
      ex_wbSel <= ex_wbSel_nx;
      fwCntrlA <= fwCntrlA_nx;
      fwCntrlB <= fwCntrlB_nx;
    end
  end

endmodule

// File: tb/tb_idex_fwd_stage.sv
// Bench for idex_fwd_stage: history-list model checked every cycle, plus directed literal checks.
module tb_idex_fwd_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_in, flush, id_valid, id_useA, id_useB, id_stuSel, id_regWrite;
  logic [2:0]  id_rsA, id_rsB, id_wrReg;
  logic [1:0]  id_wbSel;
  logic [23:0] id_ctrl;
  logic [15:0] id_inA, id_inB;
  logic        ex_valid, stall_out;
  logic [23:0] ex_ctrl;
  logic [15:0] ex_inA, ex_inB;
  logic [1:0]  ex_wbSel;
  logic [4:0]  fwCntrlA, fwCntrlB;

  int tests = 0;
  int fails = 0;

  idex_fwd_stage #(.CTRL_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush),
    .id_valid(id_valid), .id_rsA(id_rsA), .id_useA(id_useA),
    .id_rsB(id_rsB), .id_useB(id_useB), .id_stuSel(id_stuSel),
    .id_regWrite(id_regWrite), .id_wrReg(id_wrReg), .id_wbSel(id_wbSel),
    .id_ctrl(id_ctrl), .id_inA(id_inA), .id_inB(id_inB),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_inA(ex_inA), .ex_inB(ex_inB),
    .ex_wbSel(ex_wbSel), .fwCntrlA(fwCntrlA), .fwCntrlB(fwCntrlB),
    .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: list of in-flight producers, index = age (0 = in EX, 1 = in MEM)
  typedef struct packed {
    logic       v;
    logic       w;
    logic [2:0] d;
    logic [1:0] s;
  } ent_t;

  ent_t        hist [2];
  logic        e_valid;
  logic [23:0] e_ctrl;
  logic [15:0] e_inA, e_inB;
  logic [1:0]  e_wb;
  logic [4:0]  e_fwA, e_fwB;

  function automatic int youngest(input logic [2:0] rs);
    for (int age = 0; age < 2; age++)
      if (hist[age].v && hist[age].w && hist[age].d == rs) return age;
    return -1;
  endfunction

  function automatic logic [4:0] fw_word(input logic use_it, input logic [2:0] rs);
    int age;
    if (!use_it) return 5'd0;
    age = youngest(rs);
    if (age < 0) return 5'd0;
    return {1'b0, 1'b1, (age == 1), hist[age].s};
  endfunction

  function automatic logic model_stall();
    logic hit;
    hit = (id_useA && youngest(id_rsA) == 0) || (id_useB && youngest(id_rsB) == 0);
    return id_valid && !flush && hit && hist[0].s == 2'b01;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [4:0] fa, fb;
    logic       st;
    if (!rst_n) begin
      hist[0] = '0; hist[1] = '0;
      e_valid = 0; e_ctrl = 0; e_inA = 0; e_inB = 0; e_wb = 0; e_fwA = 0; e_fwB = 0;
    end else if (!stall_in) begin
      st = model_stall();
      fa = fw_word(id_useA, id_rsA);
      fb = fw_word(id_useB, id_rsB);
      hist[1] = hist[0];
      if (flush || st || !id_valid) begin
        hist[0] = '0;
        e_valid = 0; e_ctrl = 0; e_inA = 0; e_inB = 0; e_wb = 0; e_fwA = 0; e_fwB = 0;
      end else begin
        hist[0] = '{v: 1'b1, w: id_regWrite, d: id_wrReg, s: id_wbSel};
        e_valid = 1; e_ctrl = id_ctrl; e_inA = id_inA; e_inB = id_inB; e_wb = id_wbSel;
        e_fwA = fa;
        e_fwB = {id_stuSel, fb[3:0]};
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("ex_valid", 32'(ex_valid), 32'(e_valid));
    chk("ex_ctrl", 32'(ex_ctrl), 32'(e_ctrl));
    chk("ex_inA", 32'(ex_inA), 32'(e_inA));
    chk("ex_inB", 32'(ex_inB), 32'(e_inB));
    chk("ex_wbSel", 32'(ex_wbSel), 32'(e_wb));
    chk("fwCntrlA", 32'(fwCntrlA), 32'(e_fwA));
    chk("fwCntrlB", 32'(fwCntrlB), 32'(e_fwB));
    chk("stall_out", 32'(stall_out), 32'(rst_n ? model_stall() : 1'b0));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic v, input logic [2:0] ra, input logic ua,
                       input logic [2:0] rb, input logic ub, input logic stu,
                       input logic rw, input logic [2:0] wr, input logic [1:0] wb,
                       input logic [15:0] a, input logic [15:0] b);
    id_valid = v; id_rsA = ra; id_useA = ua; id_rsB = rb; id_useB = ub;
    id_stuSel = stu; id_regWrite = rw; id_wrReg = wr; id_wbSel = wb;
    id_inA = a; id_inB = b; id_ctrl = {5'd0, wr, a};
  endtask

  initial begin
    stall_in = 0; flush = 0;
    issue(0, 3'd0, 0, 3'd0, 0, 0, 0, 3'd0, 2'b00, 16'h0, 16'h0);
    tick(); tick();
    chk("reset ex_valid", 32'(ex_valid), 32'd0);
    chk("reset fwCntrlA", 32'(fwCntrlA), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: x2x ALU forward
    issue(1, 3'd0, 0, 3'd0, 0, 0, 1, 3'd1, 2'b10, 16'h0011, 16'h0022);
    tick();
    issue(1, 3'd1, 1, 3'd5, 1, 0, 0, 3'd0, 2'b10, 16'h0033, 16'h0044);
    #1 chk("t1 stall_out", 32'(stall_out), 32'd0);
    tick();
    chk("t1 fwCntrlA", 32'(fwCntrlA), 32'b01010);
    chk("t1 ex_inA", 32'(ex_inA), 32'h0033);

    // 2: m2x ALU forward through an unrelated instruction
    issue(1, 3'd0, 0, 3'd0, 0, 0, 1, 3'd2, 2'b10, 16'h0100, 16'h0200);
    tick();
    issue(1, 3'd6, 1, 3'd7, 1, 0, 1, 3'd5, 2'b10, 16'h0300, 16'h0400);
    tick();
    issue(1, 3'd6, 0, 3'd2, 1, 0, 0, 3'd0, 2'b10, 16'h0500, 16'h0600);
    tick();
    chk("t2 fwCntrlB", 32'(fwCntrlB), 32'b01110);

    // 3: load-use stall, bubble, then m2x from memory
    issue(1, 3'd0, 0, 3'd0, 0, 0, 1, 3'd3, 2'b01, 16'h0700, 16'h0800);
    tick();
    issue(1, 3'd3, 1, 3'd0, 0, 0, 0, 3'd0, 2'b10, 16'h0900, 16'h0a00);
    #1 chk("t3 stall_out", 32'(stall_out), 32'd1);
    tick();
    chk("t3 bubble", 32'(ex_valid), 32'd0);
    chk("t3 stall released", 32'(stall_out), 32'd0);
    tick();
    chk("t3 fwCntrlA", 32'(fwCntrlA), 32'b01101);
    chk("t3 ex_valid", 32'(ex_valid), 32'd1);

    // 4: store data forwarding, then EX beats MEM for the same register
    issue(1, 3'd0, 0, 3'd0, 0, 0, 1, 3'd4, 2'b10, 16'h0b00, 16'h0c00);
    tick();
    issue(1, 3'd0, 0, 3'd4, 1, 1, 0, 3'd0, 2'b10, 16'h0d00, 16'h0e00);
    tick();
    chk("t4 fwCntrlB st", 32'(fwCntrlB), 32'b11010);
    issue(1, 3'd0, 0, 3'd0, 0, 0, 1, 3'd4, 2'b10, 16'h0f00, 16'h1000);
    tick();
    issue(1, 3'd0, 0, 3'd0, 0, 0, 1, 3'd4, 2'b11, 16'h1100, 16'h1200);
    tick();
    issue(1, 3'd4, 1, 3'd0, 0, 0, 0, 3'd0, 2'b10, 16'h1300, 16'h1400);
    tick();
    chk("t4 x2x priority", 32'(fwCntrlA), 32'b01011);

    // 5: flush beats load-use, then a 3-cycle freeze
    issue(1, 3'd0, 0, 3'd0, 0, 0, 1, 3'd6, 2'b01, 16'h1500, 16'h1600);
    tick();
    issue(1, 3'd6, 1, 3'd0, 0, 0, 0, 3'd0, 2'b10, 16'h1700, 16'h1800);
    flush = 1;
    #1 chk("t5 flush stall_out", 32'(stall_out), 32'd0);
    tick();
    flush = 0;
    chk("t5 flush bubble", 32'(ex_valid), 32'd0);
    chk("t5 flush fwCntrlA", 32'(fwCntrlA), 32'd0);
    issue(1, 3'd0, 0, 3'd0, 0, 0, 1, 3'd7, 2'b10, 16'h1234, 16'h5678);
    tick();
    stall_in = 1;
    issue(1, 3'd7, 1, 3'd7, 1, 1, 1, 3'd2, 2'b11, 16'hbeef, 16'hcafe);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5 frozen ex_inA", 32'(ex_inA), 32'h1234);
    end
    stall_in = 0;
    tick();
    chk("t5 resume fwCntrlB", 32'(fwCntrlB), 32'b11010);

    // 6: async reset mid-stream
    issue(1, 3'd0, 0, 3'd0, 0, 0, 1, 3'd1, 2'b01, 16'h2100, 16'h2200);
    tick();
    issue(1, 3'd1, 1, 3'd0, 0, 0, 0, 3'd0, 2'b10, 16'h2300, 16'h2400);
    #1 rst_n = 1'b0;
    #1;
    chk("t6 rst ex_valid", 32'(ex_valid), 32'd0);
    chk("t6 rst ex_inA", 32'(ex_inA), 32'd0);
    chk("t6 rst fwCntrlB", 32'(fwCntrlB), 32'd0);
    chk("t6 rst stall_out", 32'(stall_out), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("t6 post-rst fwCntrlA", 32'(fwCntrlA), 32'd0);
    chk("t6 post-rst ex_valid", 32'(ex_valid), 32'd1);
    issue(0, 3'd0, 0, 3'd0, 0, 0, 0, 3'd0, 2'b00, 16'h0, 16'h0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
